// File: rtl/stream_demux_1_4.sv
// Purpose: 1:4 valid/ready demux; each word is routed by i_up_sel into a per-channel 2-entry FIFO.
// Latency: a word accepted at edge k is presented on its channel from cycle k+1 (registered head).
// Backpressure: o_up_ready drops only when the selected channel is full and its consumer is not popping.
module stream_demux_1_4 #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_up_valid,
  output logic         o_up_ready,
  input  logic [1:0]   i_up_sel,
  input  logic [W-1:0] i_up_data,
  output logic         o_d0_valid,
  output logic         o_d1_valid,
  output logic         o_d2_valid,
  output logic         o_d3_valid,
  input  logic         i_d0_ready,
  input  logic         i_d1_ready,
  input  logic         i_d2_ready,
  input  logic         i_d3_ready,
  output logic [W-1:0] o_d0,
  output logic [W-1:0] o_d1,
  output logic [W-1:0] o_d2,
  output logic [W-1:0] o_d3,
  output logic [7:0]   o_occ
);

  logic [1:0]   r_cnt  [4];
  logic         r_wp   [4];
  logic         r_rp   [4];
  logic [W-1:0] r_mem  [4][2];
  logic [W-1:0] r_head [4];

  logic [3:0]   w_dready;
  logic [3:0]   w_push;
  logic [3:0]   w_pop;
  logic [1:0]   w_sel_cnt;
  logic         w_up_ready;
  logic         w_rp_nxt  [4];
  logic [1:0]   w_cnt_nxt [4];

  assign w_dready = {i_d3_ready, i_d2_ready, i_d1_ready, i_d0_ready};

  // Input ready: room in the selected FIFO, or it is full but popping this cycle.
  always_comb begin
    w_sel_cnt  = r_cnt[i_up_sel];
    w_up_ready = i_rst_n & ((w_sel_cnt < 2'd2) | ((w_sel_cnt == 2'd2) & w_dready[i_up_sel]));
  end

  // Per-channel push/pop strobes and next pointer/count values.
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      w_pop[n]     = (r_cnt[n] != 2'd0) & w_dready[n];
      w_push[n]    = i_up_valid & w_up_ready & (i_up_sel == 2'(n));
      w_rp_nxt[n]  = r_rp[n] ^ w_pop[n];
      w_cnt_nxt[n] = r_cnt[n] + 2'(w_push[n]) - 2'(w_pop[n]);
    end
  end

  // FIFO state; the head register is refreshed from the next head slot, taking the
  // incoming word directly when it lands in that slot (empty push or pop+push at count 1).
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int n = 0; n < 4; n++) begin
        r_cnt[n]  <= 2'd0;
        r_wp[n]   <= 1'b0;
        r_rp[n]   <= 1'b0;
        r_head[n] <= '0;
      end
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (w_push[n]) r_mem[n][r_wp[n]] <= i_up_data;
        r_wp[n]  <= r_wp[n] ^ w_push[n];
        r_rp[n]  <= w_rp_nxt[n];
        r_cnt[n] <= w_cnt_nxt[n];
        if (w_cnt_nxt[n] != 2'd0) begin
          if (w_push[n] && (r_wp[n] == w_rp_nxt[n])) r_head[n] <= i_up_data;
          else                                       r_head[n] <= r_mem[n][w_rp_nxt[n]];
        end
      end
    end
  end

  assign o_up_ready = w_up_ready;
  assign o_d0_valid = (r_cnt[0] != 2'd0);
  assign o_d1_valid = (r_cnt[1] != 2'd0);
  assign o_d2_valid = (r_cnt[2] != 2'd0);
  assign o_d3_valid = (r_cnt[3] != 2'd0);
  assign o_d0       = r_head[0];
  assign o_d1       = r_head[1];
  assign o_d2       = r_head[2];
  assign o_d3       = r_head[3];
  assign o_occ      = {r_cnt[3], r_cnt[2], r_cnt[1], r_cnt[0]};

endmodule

// File: tb/tb_stream_demux_1_4.sv
// Bench for stream_demux_1_4: directed vector table, hand-written corner sequences and
// randomized traffic compared against a queue-per-channel reference model.
module tb_stream_demux_1_4;

  logic       i_clk = 1'b0;
  logic       i_rst_n, i_up_valid, o_up_ready;
  logic [1:0] i_up_sel;
  logic [3:0] i_up_data;
  logic       o_d0_valid, o_d1_valid, o_d2_valid, o_d3_valid;
  logic       i_d0_ready, i_d1_ready, i_d2_ready, i_d3_ready;
  logic [3:0] o_d0, o_d1, o_d2, o_d3;
  logic [7:0] o_occ;

  int n_checks = 0;
  int n_errors = 0;

  always #5 i_clk = ~i_clk;

  stream_demux_1_4 #(.W(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_up_valid(i_up_valid), .o_up_ready(o_up_ready),
    .i_up_sel(i_up_sel), .i_up_data(i_up_data),
    .o_d0_valid(o_d0_valid), .o_d1_valid(o_d1_valid),
    .o_d2_valid(o_d2_valid), .o_d3_valid(o_d3_valid),
    .i_d0_ready(i_d0_ready), .i_d1_ready(i_d1_ready),
    .i_d2_ready(i_d2_ready), .i_d3_ready(i_d3_ready),
    .o_d0(o_d0), .o_d1(o_d1), .o_d2(o_d2), .o_d3(o_d3),
    .o_occ(o_occ)
  );

  logic [3:0]      w_dv;
  logic [3:0][3:0] w_dd;
  assign w_dv = {o_d3_valid, o_d2_valid, o_d1_valid, o_d0_valid};
  assign w_dd = {o_d3, o_d2, o_d1, o_d0};

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one queue per channel, capacity 2.
  logic [3:0] q [4][$];

  function automatic bit model_ready(bit rst, logic [1:0] sel, logic [3:0] rdy);
    return rst && ((q[sel].size() < 2) || (q[sel].size() == 2 && rdy[sel]));
  endfunction

  // One cycle: drive, compare DUT against model, clock, advance model.
  task automatic cyc(input bit rst, input bit vld, input logic [1:0] sel,
                     input logic [3:0] dat, input logic [3:0] rdy);
    bit         acc;
    logic [7:0] eocc;
    logic [3:0] pops;
    i_rst_n = rst; i_up_valid = vld; i_up_sel = sel; i_up_data = dat;
    {i_d3_ready, i_d2_ready, i_d1_ready, i_d0_ready} = rdy;
    #1;
    acc = vld && model_ready(rst, sel, rdy);
    chk("up_ready", 16'(o_up_ready), 16'(model_ready(rst, sel, rdy)));
    eocc = '0;
    for (int n = 0; n < 4; n++) begin
      eocc[2*n +: 2] = 2'(q[n].size());
      chk("dvalid", 16'(w_dv[n]), 16'(q[n].size() != 0));
      if (q[n].size() != 0) chk("ddata", 16'(w_dd[n]), 16'(q[n][0]));
      pops[n] = (q[n].size() != 0) && rdy[n];
    end
    chk("occ", 16'(o_occ), 16'(eocc));
    @(posedge i_clk);
    if (!rst) begin
      for (int n = 0; n < 4; n++) q[n].delete();
    end else begin
      for (int n = 0; n < 4; n++) if (pops[n]) void'(q[n].pop_front());
      if (acc) q[sel].push_back(dat);
    end
    #1;
  endtask

  // Handshake stability: a stalled valid word must stay put until taken.
  logic [3:0]      r_pv, r_pr;
  logic [3:0][3:0] r_pd;
  logic            r_prst = 1'b0;
  always @(negedge i_clk) begin
    if (r_prst === 1'b1 && i_rst_n === 1'b1) begin
      for (int n = 0; n < 4; n++) begin
        if (r_pv[n] === 1'b1 && r_pr[n] === 1'b0) begin
          chk("stable_valid", 16'(w_dv[n]), 16'h1);
          chk("stable_data", 16'(w_dd[n]), 16'(r_pd[n]));
        end
      end
    end
    r_prst = i_rst_n;
    r_pv   = w_dv;
    r_pr   = {i_d3_ready, i_d2_ready, i_d1_ready, i_d0_ready};
    r_pd   = w_dd;
  end

  typedef struct {
    bit              rst_n;
    bit              vld;
    logic [1:0]      sel;
    logic [3:0]      dat;
    logic [3:0]      rdy;
    bit              chk;
    bit              upr;
    logic [3:0]      dv;
    logic [7:0]      occ;
    logic [3:0][3:0] dd;
  } vec_t;

  function automatic vec_t mk(bit r, bit v, logic [1:0] s, logic [3:0] d, logic [3:0] rd,
                              bit c, bit u, logic [3:0] dv, logic [7:0] oc, logic [15:0] dd);
    vec_t t;
    t.rst_n = r; t.vld = v; t.sel = s; t.dat = d; t.rdy = rd;
    t.chk = c; t.upr = u; t.dv = dv; t.occ = oc; t.dd = dd;
    return t;
  endfunction

  vec_t tbl [16];

  initial begin
    // Expected values are the DUT outputs during the row's cycle, before its clock edge.
    tbl[0]  = mk(0, 1, 2, 4'hA, 4'hF, 0, 0, 4'b0000, 8'h00, 16'h0000);
    tbl[1]  = mk(0, 1, 2, 4'hA, 4'hF, 1, 0, 4'b0000, 8'h00, 16'h0000);
    tbl[2]  = mk(1, 1, 0, 4'h1, 4'hF, 1, 1, 4'b0000, 8'h00, 16'h0000);
    tbl[3]  = mk(1, 1, 1, 4'h2, 4'hF, 1, 1, 4'b0001, 8'h01, 16'h0001);
    tbl[4]  = mk(1, 1, 2, 4'h3, 4'hF, 1, 1, 4'b0010, 8'h04, 16'h0020);
    tbl[5]  = mk(1, 1, 3, 4'h4, 4'hF, 1, 1, 4'b0100, 8'h10, 16'h0300);
    tbl[6]  = mk(1, 0, 0, 4'h0, 4'hF, 1, 1, 4'b1000, 8'h40, 16'h4000);
    tbl[7]  = mk(1, 0, 0, 4'h0, 4'hF, 1, 1, 4'b0000, 8'h00, 16'h0000);
    tbl[8]  = mk(1, 1, 1, 4'h5, 4'hD, 1, 1, 4'b0000, 8'h00, 16'h0000);
    tbl[9]  = mk(1, 1, 1, 4'h6, 4'hD, 1, 1, 4'b0010, 8'h04, 16'h0050);
    tbl[10] = mk(1, 1, 1, 4'h7, 4'hD, 1, 0, 4'b0010, 8'h08, 16'h0050);
    tbl[11] = mk(1, 1, 1, 4'h7, 4'hD, 1, 0, 4'b0010, 8'h08, 16'h0050);
    tbl[12] = mk(1, 1, 1, 4'h7, 4'hF, 1, 1, 4'b0010, 8'h08, 16'h0050);
    tbl[13] = mk(1, 0, 0, 4'h0, 4'hF, 1, 1, 4'b0010, 8'h08, 16'h0060);
    tbl[14] = mk(1, 0, 0, 4'h0, 4'hF, 1, 1, 4'b0010, 8'h04, 16'h0070);
    tbl[15] = mk(1, 0, 0, 4'h0, 4'hF, 1, 1, 4'b0000, 8'h00, 16'h0000);

    for (int i = 0; i < 16; i++) begin
      i_rst_n = tbl[i].rst_n; i_up_valid = tbl[i].vld;
      i_up_sel = tbl[i].sel;  i_up_data = tbl[i].dat;
      {i_d3_ready, i_d2_ready, i_d1_ready, i_d0_ready} = tbl[i].rdy;
      #1;
      if (tbl[i].chk) begin
        chk($sformatf("tbl%0d_up_ready", i), 16'(o_up_ready), 16'(tbl[i].upr));
        chk($sformatf("tbl%0d_dvalid", i), 16'(w_dv), 16'(tbl[i].dv));
        chk($sformatf("tbl%0d_occ", i), 16'(o_occ), 16'(tbl[i].occ));
        for (int n = 0; n < 4; n++)
          if (tbl[i].dv[n] || !tbl[i].rst_n)
            chk($sformatf("tbl%0d_d%0d", i, n), 16'(w_dd[n]), 16'(tbl[i].dd[n]));
      end
      @(posedge i_clk);
      #1;
    end

    // Isolation: channel 0 held full while channel 3 streams at one word per cycle.
    cyc(1, 1, 0, 4'h8, 4'b1000);
    cyc(1, 1, 0, 4'h9, 4'b1000);
    for (int i = 0; i < 8; i++) begin
      cyc(1, 1, 3, 4'(i + 3), 4'b1000);
      chk("iso_occ0", 16'(o_occ[1:0]), 16'h2);
      chk("iso_d0", 16'(o_d0), 16'h8);
    end
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 4'h0, 4'hF);

    // Randomized traffic with random back-pressure.
    for (int i = 0; i < 1000; i++)
      cyc(1, 1'($urandom_range(0, 1)), 2'($urandom), 4'($urandom), 4'($urandom));
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 4'h0, 4'hF);

    // Reset mid-operation with every channel full.
    for (int i = 0; i < 8; i++) cyc(1, 1, 2'(i / 2), 4'(i + 1), 4'h0);
    chk("pre_reset_occ", 16'(o_occ), 16'h00AA);
    cyc(0, 1, 2, 4'hA, 4'h0);
    chk("post_reset_occ", 16'(o_occ), 16'h0000);
    chk("post_reset_dvalid", 16'(w_dv), 16'h0000);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 4'h0, 4'hF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
